// File: rtl/decoder_bank_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | decoder_bank_arbiter: banked register file that arbitrates decode jobs     |
// | round-robin onto one external Hamming decoder.            Revision: 1.0    |
// +---------------------------------------------------------------------------+
module decoder_bank_arbiter #(
  parameter int DATA_WIDTH          = 32,
  parameter int NUM_BANKS           = 4,
  parameter int NUM_REGS_PER_BANK   = 16,
  parameter int CTRL_REG_NUM        = 1,
  parameter int STAT_REG_NUM        = 0,
  parameter int MAX_ERROR_COUNT     = 15,
  parameter int ERROR_COUNT_WIDTH   = $clog2(MAX_ERROR_COUNT + 1),
  parameter int BANK_SEL_WIDTH      = $clog2(NUM_BANKS),
  parameter int REG_BANK_ADDR_WIDTH = $clog2(NUM_REGS_PER_BANK)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           host_wr_en,
  input  logic                           host_rd_en,
  input  logic [BANK_SEL_WIDTH-1:0]      host_bank,
  input  logic [REG_BANK_ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]          host_wr_data,
  output logic [DATA_WIDTH-1:0]          host_rd_data,
  output logic                           host_rd_valid,
  output logic                           dec_req_valid,
  input  logic                           dec_req_ready,
  output logic [DATA_WIDTH-1:0]          dec_req_data,
  input  logic                           dec_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          dec_rsp_data,
  input  logic                           dec_rsp_corrected,
  input  logic                           dec_rsp_uncorrectable,
  output logic                           busy,
  output logic                           irq
);

  localparam int ECW = ERROR_COUNT_WIDTH;
  localparam int BSW = BANK_SEL_WIDTH;
  localparam int RAW = REG_BANK_ADDR_WIDTH;
  localparam logic [RAW-1:0] CTRL_IDX = RAW'(CTRL_REG_NUM);
  localparam logic [RAW-1:0] STAT_IDX = RAW'(STAT_REG_NUM);
  localparam logic [ECW-1:0] CNT_MAX  = ECW'(MAX_ERROR_COUNT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic [BSW-1:0]               ptr_q, ptr_d;
  logic [BSW-1:0]               grant_q, grant_d;
  logic [RAW-1:0]               src_q, src_d;
  logic [RAW-1:0]               dst_q, dst_d;
  logic [DATA_WIDTH-1:0]        req_data_q, req_data_d;
  logic [DATA_WIDTH-1:0]        rsp_data_q, rsp_data_d;
  logic                         rsp_corr_q, rsp_corr_d;
  logic                         rsp_unc_q, rsp_unc_d;
  logic                         stalled_q, stalled_d;
  logic [DATA_WIDTH-1:0]        regs_q [NUM_BANKS][NUM_REGS_PER_BANK];
  logic [DATA_WIDTH-1:0]        regs_d [NUM_BANKS][NUM_REGS_PER_BANK];
  logic [NUM_BANKS-1:0][ECW-1:0] cnt_q, cnt_d;
  logic [NUM_BANKS-1:0]         ovf_q, ovf_d;
  logic [NUM_BANKS-1:0]         unc_q, unc_d;
  logic [NUM_BANKS-1:0]         ill_q, ill_d;
  logic [NUM_BANKS-1:0]         done_q, done_d;
  logic [DATA_WIDTH-1:0]        rd_data_q, rd_data_d;
  logic                         rd_valid_q, rd_valid_d;

  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] stat_word;
  logic                         host_bank_ok;
  logic                         host_addr_ok;
  logic                         host_ok;
  logic                         in_service;
  logic                         host_collide;
  logic                         cand_found;
  logic [BSW-1:0]               cand_bank;
  logic [BSW-1:0]               scan_bank;
  int                           scan_idx;
  logic [RAW-1:0]               cand_src;
  logic [RAW-1:0]               cand_dst;
  logic [DATA_WIDTH-1:0]        ctrl_word;

  function automatic logic [BSW-1:0] next_bank(input logic [BSW-1:0] b);
    if (int'(b) == NUM_BANKS - 1) return '0;
    return b + 1'b1;
  endfunction

  // Out-of-range host selects only exist when the counts are not powers of two.
  if (NUM_BANKS == (1 << BSW)) begin : g_bank_full
    assign host_bank_ok = 1'b1;
  end else begin : g_bank_part
    assign host_bank_ok = (int'(host_bank) < NUM_BANKS);
  end

  if (NUM_REGS_PER_BANK == (1 << RAW)) begin : g_addr_full
    assign host_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign host_addr_ok = (int'(host_addr) < NUM_REGS_PER_BANK);
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_stat
    assign stat_word[b] = DATA_WIDTH'({(state_q != S_IDLE) && (grant_q == BSW'(b)),
                                      done_q[b], ill_q[b], unc_q[b], ovf_q[b], cnt_q[b]});
  end

  assign host_ok      = host_bank_ok && host_addr_ok;
  assign in_service   = (state_q != S_IDLE) && (host_bank == grant_q);
  assign host_collide = host_wr_en && host_ok && in_service &&
                        (host_addr != CTRL_IDX) && (host_addr != STAT_IDX);

  // Round-robin scan starting at the pointer; first bank with go set wins.
  always_comb begin
    cand_found = 1'b0;
    cand_bank  = '0;
    scan_bank  = '0;
    scan_idx   = 0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= NUM_BANKS) scan_idx = scan_idx - NUM_BANKS;
      scan_bank = BSW'(scan_idx);
      if (!cand_found && regs_q[scan_bank][CTRL_IDX][0]) begin
        cand_found = 1'b1;
        cand_bank  = scan_bank;
      end
    end
    cand_src = regs_q[cand_bank][CTRL_IDX][4 +: RAW];
    cand_dst = regs_q[cand_bank][CTRL_IDX][8 +: RAW];
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    src_d      = src_q;
    dst_d      = dst_q;
    req_data_d = req_data_q;
    rsp_data_d = rsp_data_q;
    rsp_corr_d = rsp_corr_q;
    rsp_unc_d  = rsp_unc_q;
    stalled_d  = stalled_q;
    regs_d     = regs_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    unc_d      = unc_q;
    ill_d      = ill_q;
    done_d     = done_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = host_rd_en;
    ctrl_word  = host_wr_data;
    ctrl_word[1] = 1'b0;

    if (host_rd_en) begin
      if (!host_ok) begin
        rd_data_d = '0;
      end else if (host_addr == STAT_IDX) begin
        rd_data_d         = stat_word[host_bank];
        done_d[host_bank] = 1'b0;
      end else begin
        rd_data_d = regs_q[host_bank][host_addr];
      end
    end

    // Host writes land before the engine so an engine result overrides them.
    if (host_wr_en && host_ok && (host_addr != STAT_IDX)) begin
      if (host_addr == CTRL_IDX) begin
        if (!in_service) begin
          regs_d[host_bank][CTRL_IDX] = ctrl_word;
          if (host_wr_data[1]) begin
            cnt_d[host_bank]  = '0;
            ovf_d[host_bank]  = 1'b0;
            unc_d[host_bank]  = 1'b0;
            ill_d[host_bank]  = 1'b0;
            done_d[host_bank] = 1'b0;
          end
        end
      end else begin
        regs_d[host_bank][host_addr] = host_wr_data;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cand_found) begin
          if ((cand_src == CTRL_IDX) || (cand_src == STAT_IDX) ||
              (cand_dst == CTRL_IDX) || (cand_dst == STAT_IDX)) begin
            ill_d[cand_bank]                = 1'b1;
            regs_d[cand_bank][CTRL_IDX][0]  = 1'b0;
            ptr_d                           = next_bank(cand_bank);
          end else begin
            grant_d = cand_bank;
            src_d   = cand_src;
            dst_d   = cand_dst;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        req_data_d = regs_q[grant_q][src_q];
        state_d    = S_REQ;
      end
      S_REQ: begin
        if (dec_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dec_rsp_valid) begin
          rsp_data_d = dec_rsp_data;
          rsp_corr_d = dec_rsp_corrected;
          rsp_unc_d  = dec_rsp_uncorrectable;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (host_collide && !stalled_q) begin
          stalled_d = 1'b1;
        end else begin
          stalled_d                     = 1'b0;
          regs_d[grant_q][dst_q]        = rsp_data_q;
          regs_d[grant_q][CTRL_IDX][0]  = 1'b0;
          done_d[grant_q]               = 1'b1;
          if (rsp_corr_q) begin
            if (cnt_q[grant_q] == CNT_MAX) ovf_d[grant_q] = 1'b1;
            else cnt_d[grant_q] = cnt_q[grant_q] + 1'b1;
          end
          if (rsp_unc_q) unc_d[grant_q] = 1'b1;
          ptr_d   = next_bank(grant_q);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      req_data_q <= '0;
      rsp_data_q <= '0;
      rsp_corr_q <= 1'b0;
      rsp_unc_q  <= 1'b0;
      stalled_q  <= 1'b0;
      regs_q     <= '{default: '0};
      cnt_q      <= '0;
      ovf_q      <= '0;
      unc_q      <= '0;
      ill_q      <= '0;
      done_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      req_data_q <= req_data_d;
      rsp_data_q <= rsp_data_d;
      rsp_corr_q <= rsp_corr_d;
      rsp_unc_q  <= rsp_unc_d;
      stalled_q  <= stalled_d;
      regs_q     <= regs_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      unc_q      <= unc_d;
      ill_q      <= ill_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign host_rd_data  = rd_data_q;
  assign host_rd_valid = rd_valid_q;
  assign dec_req_valid = (state_q == S_REQ);
  assign dec_req_data  = req_data_q;
  assign busy          = (state_q != S_IDLE);
  assign irq           = |done_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_bank_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_decoder_bank_arbiter: directed self-checking bench.    Revision: 1.0    |
// +---------------------------------------------------------------------------+
module tb_decoder_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_wr_en = 1'b0;
  logic        host_rd_en = 1'b0;
  logic [1:0]  host_bank = '0;
  logic [3:0]  host_addr = '0;
  logic [31:0] host_wr_data = '0;
  logic [31:0] host_rd_data;
  logic        host_rd_valid;
  logic        dec_req_valid;
  logic        dec_req_ready = 1'b0;
  logic [31:0] dec_req_data;
  logic        dec_rsp_valid = 1'b0;
  logic [31:0] dec_rsp_data = '0;
  logic        dec_rsp_corrected = 1'b0;
  logic        dec_rsp_uncorrectable = 1'b0;
  logic        busy;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;

  decoder_bank_arbiter dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .host_wr_en            (host_wr_en),
    .host_rd_en            (host_rd_en),
    .host_bank             (host_bank),
    .host_addr             (host_addr),
    .host_wr_data          (host_wr_data),
    .host_rd_data          (host_rd_data),
    .host_rd_valid         (host_rd_valid),
    .dec_req_valid         (dec_req_valid),
    .dec_req_ready         (dec_req_ready),
    .dec_req_data          (dec_req_data),
    .dec_rsp_valid         (dec_rsp_valid),
    .dec_rsp_data          (dec_rsp_data),
    .dec_rsp_corrected     (dec_rsp_corrected),
    .dec_rsp_uncorrectable (dec_rsp_uncorrectable),
    .busy                  (busy),
    .irq                   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] b, input logic [3:0] a, input logic [31:0] d);
    host_wr_en = 1'b1; host_bank = b; host_addr = a; host_wr_data = d;
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] b, input logic [3:0] a, output logic [31:0] d);
    host_rd_en = 1'b1; host_bank = b; host_addr = a;
    tick();
    host_rd_en = 1'b0;
    checks++;
    if (host_rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_valid bank%0d reg%0d: got %b want 1", b, a, host_rd_valid);
    end
    d = host_rd_data;
  endtask

  task automatic wait_req(input int max_cycles);
    int n = 0;
    while (dec_req_valid !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (dec_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: dec_req_valid=%b after %0d cycles, want 1", dec_req_valid, n);
    end
  endtask

  task automatic handshake();
    dec_req_ready = 1'b1;
    tick();
    dec_req_ready = 1'b0;
  endtask

  // Leaves the engine in its WRITE cycle.
  task automatic respond(input logic [31:0] d, input logic corr, input logic unc);
    dec_rsp_valid = 1'b1; dec_rsp_data = d;
    dec_rsp_corrected = corr; dec_rsp_uncorrectable = unc;
    tick();
    dec_rsp_valid = 1'b0; dec_rsp_corrected = 1'b0; dec_rsp_uncorrectable = 1'b0;
  endtask

  task automatic run_job(input logic [1:0] b, input logic [31:0] ctrl, input logic [31:0] exp_req,
                         input logic [31:0] rsp, input logic corr);
    host_write(b, 4'd1, ctrl);
    wait_req(10);
    checks++;
    if (dec_req_data !== exp_req) begin
      errors++;
      $display("FAIL job_req_data bank%0d: got %h want %h", b, dec_req_data, exp_req);
    end
    handshake();
    respond(rsp, corr, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({busy, irq, dec_req_valid, host_rd_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: busy/irq/req_valid/rd_valid=%b want 0000",
               {busy, irq, dec_req_valid, host_rd_valid});
    end
    reset_n = 1'b1;
    tick();
    host_read(2'd0, 4'd0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_stat: got %h want 0", rd); end
  endtask

  task automatic test_basic_job();
    host_write(2'd0, 4'd2, 32'hA5A5A5A5);
    host_read(2'd0, 4'd2, rd);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL wr_then_rd: got %h want a5a5a5a5", rd); end
    run_job(2'd0, 32'h00000321, 32'hA5A5A5A5, 32'h12345678, 1'b1);
    host_read(2'd0, 4'd3, rd);
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL basic_dst: got %h want 12345678", rd); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq_set: got %b want 1", irq); end
    host_read(2'd0, 4'd0, rd);
    checks++;
    if (rd !== 32'h081) begin errors++; $display("FAIL basic_stat1: got %h want 081", rd); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_clr: got %b want 0", irq); end
    host_read(2'd0, 4'd0, rd);
    checks++;
    if (rd !== 32'h001) begin errors++; $display("FAIL basic_stat2: got %h want 001", rd); end
    host_read(2'd0, 4'd1, rd);
    checks++;
    if (rd !== 32'h320) begin errors++; $display("FAIL basic_ctrl_go: got %h want 320", rd); end
  endtask

  task automatic test_saturation();
    host_write(2'd1, 4'd2, 32'h11110000);
    for (int k = 0; k < 16; k++) run_job(2'd1, 32'h00000321, 32'h11110000, 32'h0BADC0DE, 1'b1);
    host_read(2'd1, 4'd0, rd);
    checks++;
    if (rd !== 32'h09F) begin errors++; $display("FAIL sat_stat: got %h want 09f", rd); end
    host_write(2'd1, 4'd1, 32'h00000002);
    host_read(2'd1, 4'd0, rd);
    checks++;
    if (rd !== 32'h000) begin errors++; $display("FAIL clear_stat: got %h want 000", rd); end
  endtask

  task automatic test_round_robin();
    host_write(2'd0, 4'd4, 32'h0B0B0000);
    host_write(2'd1, 4'd4, 32'h1B1B0000);
    host_write(2'd2, 4'd4, 32'h2B2B0000);
    host_write(2'd3, 4'd4, 32'h3B3B0000);
    // Pointer is 2 here; bank3 occupies the engine while banks 2 and 0 queue up.
    host_write(2'd3, 4'd1, 32'h00000541);
    wait_req(10);
    checks++;
    if (dec_req_data !== 32'h3B3B0000) begin errors++; $display("FAIL rr_bank3: got %h want 3b3b0000", dec_req_data); end
    handshake();
    host_write(2'd2, 4'd1, 32'h00000541);
    host_write(2'd0, 4'd1, 32'h00000541);
    respond(32'h33333333, 1'b0, 1'b0);
    tick();
    wait_req(10);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dec_req_valid !== 1'b1 || dec_req_data !== 32'h0B0B0000) begin
        errors++;
        $display("FAIL rr_hold cyc%0d: valid=%b data=%h want 1/0b0b0000", k, dec_req_valid, dec_req_data);
      end
      if (k == 0) begin
        host_read(2'd0, 4'd0, rd);
        checks++;
        if (rd !== 32'h101) begin errors++; $display("FAIL rr_busy_bank: got %h want 101", rd); end
      end else begin
        tick();
      end
    end
    handshake();
    respond(32'h00000B0B, 1'b0, 1'b0);
    tick();
    wait_req(10);
    checks++;
    if (dec_req_data !== 32'h2B2B0000) begin errors++; $display("FAIL rr_bank2: got %h want 2b2b0000", dec_req_data); end
    handshake();
    host_write(2'd1, 4'd1, 32'h00000541);
    host_write(2'd0, 4'd1, 32'h00000541);
    respond(32'h00002B2B, 1'b0, 1'b0);
    tick();
    wait_req(10);
    checks++;
    if (dec_req_data !== 32'h0B0B0000) begin errors++; $display("FAIL rr_ptr3_bank0: got %h want 0b0b0000", dec_req_data); end
    handshake();
    respond(32'h0000B0B0, 1'b0, 1'b0);
    tick();
    wait_req(10);
    checks++;
    if (dec_req_data !== 32'h1B1B0000) begin errors++; $display("FAIL rr_then_bank1: got %h want 1b1b0000", dec_req_data); end
    handshake();
    respond(32'h00001B1B, 1'b0, 1'b0);
    tick();
    host_read(2'd2, 4'd5, rd);
    checks++;
    if (rd !== 32'h00002B2B) begin errors++; $display("FAIL rr_bank2_dst: got %h want 00002b2b", rd); end
    host_read(2'd1, 4'd5, rd);
    checks++;
    if (rd !== 32'h00001B1B) begin errors++; $display("FAIL rr_bank1_dst: got %h want 00001b1b", rd); end
  endtask

  task automatic test_illegal();
    logic seen = 1'b0;
    host_read(2'd3, 4'd0, rd);
    checks++;
    if (rd !== 32'h080) begin errors++; $display("FAIL ill_pre_stat: got %h want 080", rd); end
    host_write(2'd3, 4'd1, 32'h00000511);
    for (int k = 0; k < 10; k++) begin
      if (dec_req_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL ill_no_req: engine activity seen=%b want 0", seen); end
    host_read(2'd3, 4'd0, rd);
    checks++;
    if (rd !== 32'h040) begin errors++; $display("FAIL ill_stat: got %h want 040", rd); end
    host_read(2'd3, 4'd1, rd);
    checks++;
    if (rd !== 32'h510) begin errors++; $display("FAIL ill_go_clr: got %h want 510", rd); end
  endtask

  task automatic test_reset_mid_job();
    host_write(2'd0, 4'd1, 32'h00000321);
    wait_req(10);
    checks++;
    if (dec_req_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL rst_job_req: got %h want a5a5a5a5", dec_req_data); end
    handshake();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_wait_busy: got %b want 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({dec_req_valid, busy, irq} !== 3'b000) begin
      errors++;
      $display("FAIL rst_async: req_valid/busy/irq=%b want 000", {dec_req_valid, busy, irq});
    end
    tick();
    reset_n = 1'b1;
    tick();
    respond(32'hFFFFFFFF, 1'b1, 1'b1);
    tick(); tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_late_rsp_busy: got %b want 0", busy); end
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 16; a++) begin
        host_read(2'(b), 4'(a), rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rst_regs bank%0d reg%0d: got %h want 0", b, a, rd); end
      end
    end
  endtask

  task automatic test_collision();
    host_write(2'd0, 4'd2, 32'h55AA55AA);
    host_write(2'd0, 4'd1, 32'h00000321);
    wait_req(10);
    checks++;
    if (dec_req_data !== 32'h55AA55AA) begin errors++; $display("FAIL col_req: got %h want 55aa55aa", dec_req_data); end
    handshake();
    respond(32'hCAFEF00D, 1'b0, 1'b0);
    host_write(2'd0, 4'd3, 32'hDEADBEEF);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL col_stall: busy=%b want 1", busy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL col_done: busy=%b want 0", busy); end
    host_read(2'd0, 4'd3, rd);
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL col_dst: got %h want cafef00d", rd); end
    host_read(2'd0, 4'd0, rd);
    checks++;
    if (rd !== 32'h080) begin errors++; $display("FAIL col_stat: got %h want 080", rd); end
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_saturation();
    test_round_robin();
    test_illegal();
    test_reset_mid_job();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
